rotl_iter: RTL and testbench

- Multi-cycle rotate-left engine for 32-bit words. It undoes the fixed rotate-right stages in the hash datapath and serves message-schedule/self-check logic that needs a programmable left rotation.
- It rotates by up to STEP bits per cycle under a valid/ready handshake, which trades latency for a small shifter instead of a full 32-way barrel.
- It sits between the word register file and the schedule/check logic.

---
 rtl/sha_rot_pkg.sv | 21 ++
 rtl/rotl_step.sv | 27 ++
 rtl/rotl_iter.sv | 93 +++++++++
 tb/tb_rotl_iter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sha_rot_pkg.sv
// Shared types and helpers for the iterative rotate engine and its bench.
package sha_rot_pkg;

    localparam int WORD_W = 32;
    localparam int AMT_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [AMT_W-1:0]  amt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rot_state_t;

    // Number of BUSY cycles needed to rotate by amt at step bits per cycle.
    function automatic int rot_steps(input int amt, input int step);
        return (amt + step - 1) / step;
    endfunction

endpackage

// File: rtl/rotl_step.sv
// Combinational rotate of one word by 0..STEP bits.
// Optional right-rotate selection via ROTL_ITER_DIR_EN.
module rotl_step
    import sha_rot_pkg::*;
#(
    parameter int STEP = 4
) (
    input  word_t                      data,
    input  logic [$clog2(STEP+1)-1:0]  amt,
`ifdef ROTL_ITER_DIR_EN
    input  logic                       dir,
`endif
    output word_t                      result
);

    // Complementary distance; shifting a 32-bit word by 32 yields zero, so amt=0 is safe.
    logic [5:0] inv;
    assign inv = 6'(WORD_W) - 6'(amt);

`ifdef ROTL_ITER_DIR_EN
    assign result = dir ? ((data >> amt) | (data << inv))
                        : ((data << amt) | (data >> inv));
`else
    assign result = (data << amt) | (data >> inv);
`endif

endmodule

// File: rtl/rotl_iter.sv
// Multi-cycle rotate-left engine: up to STEP bits per BUSY cycle, valid/ready on both sides.
// Define ROTL_ITER_DIR_EN to add in_dir (1 = rotate right).
module rotl_iter
    import sha_rot_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    output logic  in_ready,
    input  word_t in_data,
    input  amt_t  in_amt,
`ifdef ROTL_ITER_DIR_EN
    input  logic  in_dir,
`endif
    output logic  out_valid,
    input  logic  out_ready,
    output word_t out_data,
    output logic  busy
);

    localparam int   K_W      = $clog2(STEP + 1);
    localparam amt_t STEP_AMT = amt_t'(STEP);

    rot_state_t state, state_next;
    word_t      work, step_out;
    amt_t       remaining, k_full, rem_after;
    logic       accept;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign k_full    = (remaining > STEP_AMT) ? STEP_AMT : remaining;
    assign rem_after = remaining - k_full;
    assign out_valid = (state == DONE);
    assign out_data  = work;
    assign busy      = (state != IDLE);

`ifdef ROTL_ITER_DIR_EN
    logic dir_q;

    rotl_step #(.STEP(STEP)) u_step (
        .data   (work),
        .amt    (k_full[K_W-1:0]),
        .dir    (dir_q),
        .result (step_out)
    );
`else
    rotl_step #(.STEP(STEP)) u_step (
        .data   (work),
        .amt    (k_full[K_W-1:0]),
        .result (step_out)
    );
`endif

    // NOTE: next-state is assigned a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (in_amt == '0) ? DONE : BUSY;
            BUSY: if (rem_after == '0) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the datapath is reset too, because out_data must read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            remaining <= '0;
`ifdef ROTL_ITER_DIR_EN
            dir_q     <= 1'b0;
`endif
        end else if (accept) begin
            work      <= in_data;
            remaining <= in_amt;
`ifdef ROTL_ITER_DIR_EN
            dir_q     <= in_dir;
`endif
        end else if (state == BUSY) begin
            work      <= step_out;
            remaining <= rem_after;
        end
    end

endmodule

// File: tb/tb_rotl_iter.sv
// Self-checking bench for rotl_iter: directed cases, then a random sweep against a bit-level model.
// Honours ROTL_ITER_DIR_EN when the design is built with it.
module tb_rotl_iter;
    import sha_rot_pkg::*;

    localparam int STEP = 4;

    logic  clk, rst_n;
    logic  in_valid, in_ready, out_valid, out_ready, busy;
    word_t in_data, out_data;
    amt_t  in_amt;
`ifdef ROTL_ITER_DIR_EN
    logic  in_dir;
`endif

    int vectors = 0;
    int miscompares = 0;

    rotl_iter #(.STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
`ifdef ROTL_ITER_DIR_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: move each bit to its new index modulo 32.
    function automatic word_t ref_rot(input word_t x, input int n, input bit right);
        word_t r = '0;
        for (int i = 0; i < 32; i++) begin
            if (right) r[(i + 32 - n) % 32] = x[i];
            else       r[(i + n) % 32]      = x[i];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: present, wait for result, hold stall cycles, then hand off.
    task automatic run_req(input word_t data, input amt_t amt, input bit dir,
                           input int stall, input string tag);
        int    lat;
        int    guard;
        word_t exp;
        in_data  = data;
        in_amt   = amt;
`ifdef ROTL_ITER_DIR_EN
        in_dir   = dir;
`endif
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = ref_rot(data, int'(amt), dir);
        check({tag, " latency"}, 32'(lat), 32'(1 + rot_steps(int'(amt), STEP)));
        check({tag, " data"}, out_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold data"}, out_data, exp);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post valid"}, 32'(out_valid), 32'd0);
        check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " post busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        in_amt    = 5'd7;
        out_ready = 1'b0;
`ifdef ROTL_ITER_DIR_EN
        in_dir    = 1'b0;
`endif
        #3;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reset held out_valid", 32'(out_valid), 32'd0);
        check("reset held busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Accept lands on the first edge after release.
        run_req(32'h8ACF_0246, 5'd19, 1'b0, 0, "inverse");
        run_req(32'h8000_0000, 5'd1,  1'b0, 0, "wrap1");
        run_req(32'hDEAD_BEEF, 5'd0,  1'b0, 0, "zero");
        run_req(32'h0000_0001, 5'd31, 1'b0, 0, "amt31");
        run_req(32'h0000_0001, 5'd19, 1'b0, 10, "backpressure");

        // Abort during BUSY.
        in_data  = 32'h0000_0001;
        in_amt   = 5'd31;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("midrst no output", 32'(out_valid), 32'd0);
        end
        run_req(32'h0000_0001, 5'd4, 1'b0, 0, "after reset");

        for (int n = 0; n < 1000; n++) begin
            bit dir;
`ifdef ROTL_ITER_DIR_EN
            dir = 1'($urandom_range(0, 1));
`else
            dir = 1'b0;
`endif
            run_req(word_t'($urandom), amt_t'($urandom_range(0, 31)), dir,
                    int'($urandom_range(0, 3)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
